// File: rtl/irq_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter.
package irq_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_GAP  = 2'd2,
        ST_ACK2 = 2'd3
    } arb_state_e;

    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    // Reset value of lowest_prio depends on the instance width, so it is a function.
    function automatic logic [2:0] LOWEST_PRIO_RESET(input int unsigned num_irq);
        return 3'(num_irq - 1);
    endfunction

endpackage

// File: rtl/irq_prio_resolver.sv
// Circular find-first: scans from lowest_i+1 upward (mod NUM_IRQ) and reports the
// first set request together with its rank (0 = highest priority).
module irq_prio_resolver #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req_i,
    input  logic [2:0]         lowest_i,
    output logic               found_o,
    output logic [2:0]         level_o,
    output logic [2:0]         rank_o
);

    logic [3:0] idx;

    always_comb begin
        found_o = 1'b0;
        level_o = '0;
        rank_o  = '0;
        idx     = '0;
        // Descending scan so the smallest rank is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            idx = {1'b0, lowest_i} + 4'd1 + 4'(i);
            if (idx >= 4'(NUM_IRQ)) begin
                idx = idx - 4'(NUM_IRQ);
            end
            if (req_i[idx[2:0]]) begin
                found_o = 1'b1;
                level_o = idx[2:0];
                rank_o  = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// 8259-style interrupt arbiter: synchronizes requests, resolves circular priority and
// runs the two-pulse acknowledge. Define IRQ_ARBITER_ROTATE_EN for rotation and set_prio.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               cfg_level,
    input  logic [NUM_IRQ-1:0] cfg_mask,
    input  logic               cfg_aeoi,
    input  logic               cfg_rotate_auto,
    input  logic [4:0]         cfg_vector_base,
    input  logic               init,
    input  logic               eoi_ns,
    input  logic               eoi_sp,
    input  logic               set_prio,
    input  logic [2:0]         eoi_level,
    input  logic [2:0]         prio_level,
    input  logic               inta,
    output logic               int_req,
    output logic [7:0]         vector,
    output logic               vector_valid,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr
);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] synced_prev_q;
    logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d;
    logic [NUM_IRQ-1:0] irr_set, irr_clr, isr_set, isr_clr;
    logic [NUM_IRQ-1:0] synced, rise, irr_eff;
    arb_state_e         state_q, state_d;
    logic               inta_q, inta_rise, inta_fall;
    logic               ack1_entry, ack2_exit;
    logic [2:0]         level_q, level_d, lowest_q, lowest_d;
    logic               spurious_q, spurious_d;
    logic               int_req_q, int_req_d, vld_q, vld_d;
    logic [7:0]         vector_q, vector_d;
    logic               irr_found, isr_found;
    logic [2:0]         irr_level, isr_level, irr_rank, isr_rank;

    irq_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_irr_res (
        .req_i    (irr_eff),
        .lowest_i (lowest_q),
        .found_o  (irr_found),
        .level_o  (irr_level),
        .rank_o   (irr_rank)
    );

    irq_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_res (
        .req_i    (isr_q),
        .lowest_i (lowest_q),
        .found_o  (isr_found),
        .level_o  (isr_level),
        .rank_o   (isr_rank)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= irq;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    always_comb begin
        synced    = sync_q[SYNC_STAGES-1];
        rise      = synced & ~synced_prev_q;
        irr_eff   = irr_q & ~cfg_mask;
        inta_rise = inta & ~inta_q;
        inta_fall = ~inta & inta_q;

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (inta_rise) state_d = ST_ACK1;
            ST_ACK1: if (inta_fall) state_d = ST_GAP;
            ST_GAP:  if (inta_rise) state_d = ST_ACK2;
            ST_ACK2: if (inta_fall) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ack1_entry = (state_q == ST_IDLE) && (state_d == ST_ACK1);
        ack2_exit  = (state_q == ST_ACK2) && (state_d == ST_IDLE);

        irr_set    = rise;
        irr_clr    = '0;
        isr_set    = '0;
        isr_clr    = '0;
        level_d    = level_q;
        spurious_d = spurious_q;
        if (ack1_entry) begin
            if (irr_found) begin
                level_d            = irr_level;
                spurious_d         = 1'b0;
                isr_set[irr_level] = 1'b1;
                irr_clr[irr_level] = 1'b1;
            end else begin
                level_d    = SPURIOUS_LEVEL;
                spurious_d = 1'b1;
            end
        end
        if (ack2_exit && cfg_aeoi && !spurious_q) isr_clr[level_q] = 1'b1;
        if (eoi_ns && isr_found) isr_clr[isr_level] = 1'b1;
        if (eoi_sp && ({1'b0, eoi_level} < 4'(NUM_IRQ))) isr_clr[eoi_level] = 1'b1;

        // Clears are applied first so a same-cycle set always wins.
        irr_d = cfg_level ? synced : ((irr_q & ~irr_clr) | irr_set);
        isr_d = (isr_q & ~isr_clr) | isr_set;

`ifdef IRQ_ARBITER_ROTATE_EN
        lowest_d = lowest_q;
        if (ack2_exit && cfg_aeoi && cfg_rotate_auto && !spurious_q) lowest_d = level_q;
        if (set_prio && ({1'b0, prio_level} < 4'(NUM_IRQ))) lowest_d = prio_level;
`else
        lowest_d = LOWEST_PRIO_RESET(NUM_IRQ);
`endif

        int_req_d = (state_q == ST_IDLE) && (state_d == ST_IDLE) && irr_found &&
                    (!isr_found || (irr_rank < isr_rank));
        vld_d     = (state_d == ST_ACK2) && inta;
        vector_d  = vld_d ? {cfg_vector_base, level_q} : 8'h00;

        if (init) begin
            state_d   = ST_IDLE;
            irr_d     = '0;
            isr_d     = '0;
            lowest_d  = LOWEST_PRIO_RESET(NUM_IRQ);
            int_req_d = 1'b0;
            vld_d     = 1'b0;
            vector_d  = 8'h00;
        end
    end

`ifndef IRQ_ARBITER_ROTATE_EN
    logic unused_rotate_inputs;
    assign unused_rotate_inputs = ^{cfg_rotate_auto, set_prio, prio_level};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            synced_prev_q <= '0;
            irr_q         <= '0;
            isr_q         <= '0;
            inta_q        <= 1'b0;
            level_q       <= '0;
            spurious_q    <= 1'b0;
            lowest_q      <= LOWEST_PRIO_RESET(NUM_IRQ);
            int_req_q     <= 1'b0;
            vld_q         <= 1'b0;
            vector_q      <= 8'h00;
        end else begin
            state_q       <= state_d;
            synced_prev_q <= synced;
            irr_q         <= irr_d;
            isr_q         <= isr_d;
            inta_q        <= inta;
            level_q       <= level_d;
            spurious_q    <= spurious_d;
            lowest_q      <= lowest_d;
            int_req_q     <= int_req_d;
            vld_q         <= vld_d;
            vector_q      <= vector_d;
        end
    end

    assign int_req      = int_req_q;
    assign vector       = vector_q;
    assign vector_valid = vld_q;
    assign irr          = irr_q;
    assign isr          = isr_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter (default NUM_IRQ=8, SYNC_STAGES=2).
module tb_irq_arbiter;

    localparam int NUM  = 8;
    localparam int SYNC = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NUM-1:0] irq;
    logic           cfg_level;
    logic [NUM-1:0] cfg_mask;
    logic           cfg_aeoi;
    logic           cfg_rotate_auto;
    logic [4:0]     cfg_vector_base;
    logic           init, eoi_ns, eoi_sp, set_prio;
    logic [2:0]     eoi_level, prio_level;
    logic           inta;
    logic           int_req;
    logic [7:0]     vector;
    logic           vector_valid;
    logic [NUM-1:0] irr, isr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    irq_arbiter #(.NUM_IRQ(NUM), .SYNC_STAGES(SYNC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .irq             (irq),
        .cfg_level       (cfg_level),
        .cfg_mask        (cfg_mask),
        .cfg_aeoi        (cfg_aeoi),
        .cfg_rotate_auto (cfg_rotate_auto),
        .cfg_vector_base (cfg_vector_base),
        .init            (init),
        .eoi_ns          (eoi_ns),
        .eoi_sp          (eoi_sp),
        .set_prio        (set_prio),
        .eoi_level       (eoi_level),
        .prio_level      (prio_level),
        .inta            (inta),
        .int_req         (int_req),
        .vector          (vector),
        .vector_valid    (vector_valid),
        .irr             (irr),
        .isr             (isr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full two-pulse acknowledge; returns what was on the bus during the second pulse.
    task automatic do_ack(output logic [7:0] vec, output logic vld);
        inta = 1'b1; tick(1);
        inta = 1'b0; tick(1);
        inta = 1'b1; tick(1);
        vec = vector;
        vld = vector_valid;
        inta = 1'b0; tick(1);
    endtask

    task automatic clean();
        irq = '0; cfg_mask = '0; cfg_level = 1'b0; cfg_aeoi = 1'b0; cfg_rotate_auto = 1'b0;
        eoi_ns = 1'b0; eoi_sp = 1'b0; set_prio = 1'b0; inta = 1'b0;
        tick(SYNC + 2);
        init = 1'b1; tick(1);
        init = 1'b0; tick(1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        total_cnt++; if (int_req !== 1'b0) $display("FAIL reset_int_req got=%b exp=0", int_req); else pass_cnt++;
        total_cnt++; if (vector !== 8'h00) $display("FAIL reset_vector got=%h exp=00", vector); else pass_cnt++;
        total_cnt++; if (vector_valid !== 1'b0) $display("FAIL reset_vvalid got=%b exp=0", vector_valid); else pass_cnt++;
        total_cnt++; if (irr !== 8'h00) $display("FAIL reset_irr got=%h exp=00", irr); else pass_cnt++;
        total_cnt++; if (isr !== 8'h00) $display("FAIL reset_isr got=%h exp=00", isr); else pass_cnt++;
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_edge_ack();
        logic [7:0] vec;
        logic       vld;
        clean();
        irq[3] = 1'b1;
        tick(SYNC + 1);
        total_cnt++; if (int_req !== 1'b0) $display("FAIL edge_int_req_early got=%b exp=0", int_req); else pass_cnt++;
        total_cnt++; if (irr !== 8'h08) $display("FAIL edge_irr_set got=%h exp=08", irr); else pass_cnt++;
        tick(1);
        total_cnt++; if (int_req !== 1'b1) $display("FAIL edge_int_req got=%b exp=1", int_req); else pass_cnt++;
        do_ack(vec, vld);
        total_cnt++; if (vec !== 8'h43) $display("FAIL edge_vector got=%h exp=43", vec); else pass_cnt++;
        total_cnt++; if (vld !== 1'b1) $display("FAIL edge_vvalid got=%b exp=1", vld); else pass_cnt++;
        total_cnt++; if (isr !== 8'h08) $display("FAIL edge_isr got=%h exp=08", isr); else pass_cnt++;
        total_cnt++; if (irr !== 8'h00) $display("FAIL edge_irr_clr got=%h exp=00", irr); else pass_cnt++;
        total_cnt++; if (vector_valid !== 1'b0) $display("FAIL edge_vvalid_after got=%b exp=0", vector_valid); else pass_cnt++;
        tick(1);
        total_cnt++; if (int_req !== 1'b0) $display("FAIL edge_int_req_idle got=%b exp=0", int_req); else pass_cnt++;
    endtask

    task automatic test_nesting();
        logic [7:0] vec;
        logic       vld;
        clean();
        irq[5] = 1'b1;
        tick(SYNC + 2);
        do_ack(vec, vld);
        total_cnt++; if (isr !== 8'h20) $display("FAIL nest_isr5 got=%h exp=20", isr); else pass_cnt++;
        irq[2] = 1'b1;
        tick(SYNC + 2);
        total_cnt++; if (int_req !== 1'b1) $display("FAIL nest_higher_preempts got=%b exp=1", int_req); else pass_cnt++;

        clean();
        irq[5] = 1'b1;
        tick(SYNC + 2);
        do_ack(vec, vld);
        irq[6] = 1'b1;
        tick(SYNC + 3);
        total_cnt++; if (irr !== 8'h40) $display("FAIL nest_irr6 got=%h exp=40", irr); else pass_cnt++;
        total_cnt++; if (int_req !== 1'b0) $display("FAIL nest_lower_blocked got=%b exp=0", int_req); else pass_cnt++;
        eoi_ns = 1'b1; tick(1);
        eoi_ns = 1'b0;
        total_cnt++; if (isr !== 8'h00) $display("FAIL nest_eoi_ns_isr got=%h exp=00", isr); else pass_cnt++;
        tick(1);
        total_cnt++; if (int_req !== 1'b1) $display("FAIL nest_after_eoi got=%b exp=1", int_req); else pass_cnt++;
    endtask

    task automatic test_spurious();
        logic [7:0] vec;
        logic       vld;
        clean();
        cfg_level = 1'b1;
        irq[4] = 1'b1;
        tick(SYNC + 2);
        total_cnt++; if (int_req !== 1'b1) $display("FAIL spur_int_req got=%b exp=1", int_req); else pass_cnt++;
        irq[4] = 1'b0;
        tick(SYNC + 1);
        total_cnt++; if (irr !== 8'h00) $display("FAIL spur_irr_follow got=%h exp=00", irr); else pass_cnt++;
        do_ack(vec, vld);
        total_cnt++; if (vec !== 8'h47) $display("FAIL spur_vector got=%h exp=47", vec); else pass_cnt++;
        total_cnt++; if (isr !== 8'h00) $display("FAIL spur_isr got=%h exp=00", isr); else pass_cnt++;
    endtask

    task automatic test_rotate();
        logic [7:0] vec;
        logic       vld;
        logic [2:0] exp_low;
        logic [7:0] exp_vec2;
        logic [7:0] exp_irr2;
`ifdef IRQ_ARBITER_ROTATE_EN
        exp_low = 3'd2; exp_vec2 = 8'h43; exp_irr2 = 8'h04;
`else
        exp_low = 3'd7; exp_vec2 = 8'h42; exp_irr2 = 8'h08;
`endif
        clean();
        cfg_aeoi = 1'b1; cfg_rotate_auto = 1'b1;
        irq[2] = 1'b1;
        tick(SYNC + 2);
        do_ack(vec, vld);
        total_cnt++; if (vec !== 8'h42) $display("FAIL rot_first_vector got=%h exp=42", vec); else pass_cnt++;
        total_cnt++; if (isr !== 8'h00) $display("FAIL rot_aeoi_isr got=%h exp=00", isr); else pass_cnt++;
        total_cnt++; if (dut.lowest_q !== exp_low) $display("FAIL rot_lowest got=%0d exp=%0d", dut.lowest_q, exp_low); else pass_cnt++;
        irq = '0;
        tick(SYNC + 1);
        irq[2] = 1'b1; irq[3] = 1'b1;
        tick(SYNC + 2);
        total_cnt++; if (int_req !== 1'b1) $display("FAIL rot_int_req got=%b exp=1", int_req); else pass_cnt++;
        do_ack(vec, vld);
        total_cnt++; if (vec !== exp_vec2) $display("FAIL rot_grant got=%h exp=%h", vec, exp_vec2); else pass_cnt++;
        total_cnt++; if (irr !== exp_irr2) $display("FAIL rot_irr_left got=%h exp=%h", irr, exp_irr2); else pass_cnt++;
    endtask

    task automatic test_mask_eoi_sp();
        logic [7:0] vec;
        logic       vld;
        clean();
        cfg_mask = 8'h08;
        irq[3] = 1'b1;
        tick(SYNC + 3);
        total_cnt++; if (int_req !== 1'b0) $display("FAIL mask_blocks got=%b exp=0", int_req); else pass_cnt++;
        cfg_mask = 8'h00;
        tick(1);
        total_cnt++; if (int_req !== 1'b1) $display("FAIL mask_release got=%b exp=1", int_req); else pass_cnt++;
        do_ack(vec, vld);
        eoi_level = 3'd2; eoi_sp = 1'b1; tick(1);
        total_cnt++; if (isr !== 8'h08) $display("FAIL eoi_sp_other got=%h exp=08", isr); else pass_cnt++;
        eoi_level = 3'd3; tick(1);
        eoi_sp = 1'b0;
        total_cnt++; if (isr !== 8'h00) $display("FAIL eoi_sp_clear got=%h exp=00", isr); else pass_cnt++;
    endtask

    task automatic test_reset_init_midseq();
        clean();
        irq[1] = 1'b1;
        tick(SYNC + 2);
        inta = 1'b1; tick(1);
        total_cnt++; if (isr !== 8'h02) $display("FAIL mid_isr_ack1 got=%h exp=02", isr); else pass_cnt++;
        inta = 1'b0; tick(1);
        reset_n = 1'b0; tick(1);
        total_cnt++; if (dut.state_q !== irq_arbiter_pkg::ST_IDLE) $display("FAIL mid_reset_state got=%0d exp=0", dut.state_q); else pass_cnt++;
        total_cnt++; if ({int_req, vector, vector_valid, irr, isr} !== 26'd0)
            $display("FAIL mid_reset_outputs got=%b/%h/%b/%h/%h exp=all 0", int_req, vector, vector_valid, irr, isr);
        else pass_cnt++;
        reset_n = 1'b1;

        clean();
        irq[1] = 1'b1;
        tick(SYNC + 2);
        inta = 1'b1; tick(1);
        inta = 1'b0; tick(1);
        inta = 1'b1; tick(1);
        total_cnt++; if (vector_valid !== 1'b1) $display("FAIL mid_ack2_valid got=%b exp=1", vector_valid); else pass_cnt++;
        total_cnt++; if (vector !== 8'h41) $display("FAIL mid_ack2_vector got=%h exp=41", vector); else pass_cnt++;
        init = 1'b1; tick(1);
        init = 1'b0;
        total_cnt++; if (vector_valid !== 1'b0) $display("FAIL init_vvalid got=%b exp=0", vector_valid); else pass_cnt++;
        total_cnt++; if (isr !== 8'h00) $display("FAIL init_isr got=%h exp=00", isr); else pass_cnt++;
        total_cnt++; if (dut.state_q !== irq_arbiter_pkg::ST_IDLE) $display("FAIL init_state got=%0d exp=0", dut.state_q); else pass_cnt++;
        inta = 1'b0; tick(1);
    endtask

    initial begin
        reset_n = 1'b0; irq = '0; cfg_level = 1'b0; cfg_mask = '0; cfg_aeoi = 1'b0;
        cfg_rotate_auto = 1'b0; cfg_vector_base = 5'h08; init = 1'b0; eoi_ns = 1'b0;
        eoi_sp = 1'b0; set_prio = 1'b0; eoi_level = '0; prio_level = '0; inta = 1'b0;
        test_reset();
        test_edge_ack();
        test_nesting();
        test_spurious();
        test_rotate();
        test_mask_eoi_sp();
        test_reset_init_midseq();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
